// File: rtl/vscale_dmem_responder.sv
// HASTI-style memory responder: pipelined address/data phases over a local word array,
// with programmable wait states, byte/half/word writes and ERROR responses for bad accesses.
module vscale_dmem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,  // must be word-aligned
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_resp
);

    localparam int         AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR, S_ERR2} state_t;

    state_t        r_state, w_state_next, w_acc_state;
    logic [2:0]    r_wait_cnt, w_wait_cnt_next;
    logic [AW-1:0] r_word;
    logic [1:0]    r_lane;
    logic [2:0]    r_size;
    logic          r_is_write;
    logic          r_is_err;
    logic [3:0]    r_fwd_be;
    logic [31:0]   r_fwd_data;
    logic [31:0]   r_rd_raw;
    logic [31:0]   r_mem [MEM_WORDS];

    logic [29:0]   w_word_off;
    logic [AW-1:0] w_word;
    logic          w_in_window;
    logic          w_misaligned;
    logic          w_req_err;
    logic          w_ready;
    logic          w_accept;
    logic [3:0]    w_be;
    logic          w_mem_we;
    logic          w_rd_load;
    logic [AW-1:0] w_rd_idx;
    logic          w_fwd;
    logic [31:0]   w_rd_word;

    // Request decode on the live address phase; the window test spans all 32 address bits.
    assign w_word_off   = mem_addr[31:2] - BASE_ADDR[31:2];
    assign w_word       = w_word_off[AW-1:0];
    assign w_in_window  = ((w_word_off >> AW) == '0);
    assign w_misaligned = ((mem_size == 3'd1) && mem_addr[0]) ||
                          ((mem_size == 3'd2) && (mem_addr[1:0] != 2'd0));
    assign w_req_err    = !w_in_window || (mem_size > 3'd2) || w_misaligned ||
                          (mem_read && mem_write);

    assign w_ready   = (r_state != S_WAIT) && (r_state != S_ERR);
    assign mem_ready = w_ready;
    assign w_accept  = w_ready && (mem_read || mem_write);

    always_comb begin
        w_acc_state = S_DATA;
        if (w_req_err) begin
            w_acc_state = S_ERR;
        end else if (WS != 3'd0) begin
            w_acc_state = S_WAIT;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        mem_resp        = 1'b0;
        mem_rdata       = 32'h0;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (r_state == S_DATA && !r_is_write) begin
                    mem_rdata = w_rd_word;
                end
                if (r_state == S_ERR2) begin
                    mem_resp = 1'b1;
                end
                if (w_accept) begin
                    w_state_next    = w_acc_state;
                    w_wait_cnt_next = WS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_wait_cnt_next = r_wait_cnt - 3'd1;
                if (r_wait_cnt <= 3'd1) begin
                    w_state_next = S_DATA;
                end
            end
            S_ERR: begin
                mem_resp     = 1'b1;
                w_state_next = S_ERR2;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
            r_word     <= '0;
            r_lane     <= 2'd0;
            r_size     <= 3'd0;
            r_is_write <= 1'b0;
            r_is_err   <= 1'b0;
            r_fwd_be   <= 4'd0;
            r_fwd_data <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_accept) begin
                r_word     <= w_word;
                r_lane     <= mem_addr[1:0];
                r_size     <= mem_size;
                r_is_write <= mem_write;
                r_is_err   <= w_req_err;
            end
            if (w_rd_load) begin
                r_fwd_be   <= w_fwd ? w_be : 4'd0;
                r_fwd_data <= mem_wdata;
            end
        end
    end

    // Lane enables for the captured write; size is known legal whenever a write commits.
    always_comb begin
        w_be = 4'b1111;
        if (r_size == 3'd0) begin
            w_be = 4'b0001 << r_lane;
        end else if (r_size == 3'd1) begin
            w_be = r_lane[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign w_mem_we = (r_state == S_DATA) && r_is_write && !r_is_err;

    // The read is launched on the edge entering DATA: from the captured index after a stall,
    // otherwise from the request being accepted right now.
    assign w_rd_load = (w_state_next == S_DATA) &&
                       ((r_state == S_WAIT) ? !r_is_write : mem_read);
    assign w_rd_idx  = (r_state == S_WAIT) ? r_word : w_word;
    assign w_fwd     = w_mem_we && (r_word == w_rd_idx);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_word][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
        if (w_rd_load) begin
            r_rd_raw <= r_mem[w_rd_idx];
        end
    end

    // A back-to-back read of the word just written sees the old array contents; patch in new lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign w_rd_word[8*gi +: 8] = r_fwd_be[gi] ? r_fwd_data[8*gi +: 8]
                                                       : r_rd_raw[8*gi +: 8];
        end
    endgenerate

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed bench: a zero-wait responder at base 0 and a three-wait responder at base 0x1000.
module tb_vscale_dmem_responder;

    logic        clk;
    logic        a_rst_n, b_rst_n;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_read, b_read, a_write, b_write;
    logic [2:0]  a_size, b_size;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, b_ready, a_resp, b_resp;

    int n_checks = 0;
    int n_errors = 0;

    vscale_dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_a (
        .clk(clk), .reset_n(a_rst_n), .mem_addr(a_addr), .mem_read(a_read),
        .mem_write(a_write), .mem_size(a_size), .mem_wdata(a_wdata),
        .mem_rdata(a_rdata), .mem_ready(a_ready), .mem_resp(a_resp));

    vscale_dmem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .mem_addr(b_addr), .mem_read(b_read),
        .mem_write(b_write), .mem_size(b_size), .mem_wdata(b_wdata),
        .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_resp(b_resp));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit d, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
        if (!d) begin
            a_read = rd; a_write = wr; a_addr = addr; a_size = size; a_wdata = wdata;
        end else begin
            b_read = rd; b_write = wr; b_addr = addr; b_size = size; b_wdata = wdata;
        end
    endtask

    function automatic logic cur_ready(input bit d);
        return d ? b_ready : a_ready;
    endfunction

    function automatic logic cur_resp(input bit d);
        return d ? b_resp : a_resp;
    endfunction

    function automatic logic [31:0] cur_rdata(input bit d);
        return d ? b_rdata : a_rdata;
    endfunction

    // One isolated transfer. The address bus is scrambled during the data phase to show that
    // only the accepted request matters. waits counts cycles with ready low (bounded).
    task automatic xfer(input bit d, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic resp,
                        output logic first_resp, output int waits);
        drive(d, rd, wr, addr, size, 32'h0);
        tick();
        drive(d, 1'b0, 1'b0, 32'hFFFF_FFF0, 3'd3, wdata);
        waits = 0;
        @(negedge clk);
        first_resp = cur_resp(d);
        while (!cur_ready(d) && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        rdata = cur_rdata(d);
        resp  = cur_resp(d);
        tick();
        drive(d, 1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
    } err_vec_t;

    initial begin
        logic [31:0] rdata;
        logic        resp, first_resp;
        int          waits;
        err_vec_t    errs [5];

        errs[0] = '{1'b1, 1'b0, 32'h0000_0100, 3'd2};  // one past the window
        errs[1] = '{1'b0, 1'b1, 32'h0000_0022, 3'd2};  // misaligned word write
        errs[2] = '{1'b1, 1'b0, 32'h0000_0020, 3'd3};  // illegal size
        errs[3] = '{1'b1, 1'b1, 32'h0000_0020, 3'd2};  // read and write together
        errs[4] = '{1'b1, 1'b0, 32'h0000_0021, 3'd1};  // misaligned half

        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_ready", a_ready, 1);
        check_eq("rst_a_resp",  a_resp,  0);
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_ready", b_ready, 1);
        check_eq("rst_b_resp",  b_resp,  0);
        check_eq("rst_b_rdata", b_rdata, 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // Back-to-back write then read of the same word, no bubbles.
        drive(1'b0, 1'b0, 1'b1, 32'h10, 3'd2, 32'h0);
        @(negedge clk);
        check_eq("t1_addr_ready", a_ready, 1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("t1_wr_ready", a_ready, 1);
        check_eq("t1_wr_resp",  a_resp,  0);
        check_eq("t1_wr_rdata", a_rdata, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        @(negedge clk);
        check_eq("t1_rd_ready", a_ready, 1);
        check_eq("t1_rd_resp",  a_resp,  0);
        check_eq("t1_rd_rdata", a_rdata, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check_eq("t1_idle_rdata", a_rdata, 0);
        tick();

        // Lane merging: word, then byte into lane 1, then half into lanes 2..3.
        xfer(1'b0, 1'b0, 1'b1, 32'h20, 3'd2, 32'h1122_3344, rdata, resp, first_resp, waits);
        xfer(1'b0, 1'b0, 1'b1, 32'h21, 3'd0, 32'h0000_AA00, rdata, resp, first_resp, waits);
        check_eq("t2_byte_resp", resp, 0);
        xfer(1'b0, 1'b0, 1'b1, 32'h22, 3'd1, 32'hBBBB_0000, rdata, resp, first_resp, waits);
        xfer(1'b0, 1'b1, 1'b0, 32'h20, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t2_merge_rdata", rdata, 32'hBBBB_AA44);
        check_eq("t2_merge_waits", waits, 0);

        // Last word of the window is legal.
        xfer(1'b0, 1'b0, 1'b1, 32'hFC, 3'd2, 32'h5A5A_5A5A, rdata, resp, first_resp, waits);
        xfer(1'b0, 1'b1, 1'b0, 32'hFC, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t4_top_rdata", rdata, 32'h5A5A_5A5A);
        check_eq("t4_top_resp",  resp,  0);

        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, errs[i].rd, errs[i].wr, errs[i].addr, errs[i].size, 32'hFFFF_FFFF,
                 rdata, resp, first_resp, waits);
            check_eq($sformatf("t4_err%0d_resp1", i), first_resp, 1);
            check_eq($sformatf("t4_err%0d_waits", i), waits, 1);
            check_eq($sformatf("t4_err%0d_resp2", i), resp, 1);
            check_eq($sformatf("t4_err%0d_rdata", i), rdata, 0);
        end
        xfer(1'b0, 1'b1, 1'b0, 32'h20, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t4_keep_20", rdata, 32'hBBBB_AA44);
        xfer(1'b0, 1'b1, 1'b0, 32'hFC, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t4_keep_fc", rdata, 32'h5A5A_5A5A);

        // Wait states: exactly three stall cycles, address scrambled during the stall.
        xfer(1'b1, 1'b0, 1'b1, 32'h1004, 3'd2, 32'hCAFE_F00D, rdata, resp, first_resp, waits);
        check_eq("t3_wr_waits", waits, 3);
        check_eq("t3_wr_resp",  resp,  0);
        xfer(1'b1, 1'b1, 1'b0, 32'h1004, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t3_rd_waits", waits, 3);
        check_eq("t3_rd_stall_resp", first_resp, 0);
        check_eq("t3_rd_rdata", rdata, 32'hCAFE_F00D);
        xfer(1'b1, 1'b1, 1'b0, 32'h0FFC, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t3_below_base_resp", resp, 1);
        check_eq("t3_below_base_waits", waits, 1);

        // Reset in the middle of a stalled write drops the write.
        drive(1'b1, 1'b0, 1'b1, 32'h1004, 3'd2, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 3'd2, 32'h1234_5678);
        tick();
        #2;
        check_eq("t5_pre_ready", b_ready, 0);
        b_rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ready", b_ready, 1);
        check_eq("t5_rst_resp",  b_resp,  0);
        check_eq("t5_rst_rdata", b_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        tick();
        xfer(1'b1, 1'b1, 1'b0, 32'h1004, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t5_kept_rdata", rdata, 32'hCAFE_F00D);
        check_eq("t5_kept_waits", waits, 3);
        xfer(1'b1, 1'b0, 1'b1, 32'h1008, 3'd2, 32'h0BAD_CAFE, rdata, resp, first_resp, waits);
        xfer(1'b1, 1'b1, 1'b0, 32'h1008, 3'd2, 32'h0, rdata, resp, first_resp, waits);
        check_eq("t5_after_rdata", rdata, 32'h0BAD_CAFE);
        check_eq("t5_after_resp",  resp,  0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
